// File: rtl/delay_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_ram
// Purpose  : Circular sample delay line. Every cycle with wr high stores one
//            sample at the write pointer. A read request returns the sample
//            written `offset` samples before the most recent one.
//            Reads go through a 4-state FSM (IDLE, ADDR, MEM, DONE).
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            wr, data_in       - write strobe and sample
//            rd, offset        - read request (sampled in IDLE) and delay
//            read_finish       - one-cycle pulse, data_out valid with it
//            data_out          - last read sample, held until next read
//            busy              - FSM not in IDLE
// Options  : DELAY_LINE_FILL_TRACK_EN - saturating fill counter; a read
//            deeper than the number of stored samples returns zero.
// Revision : 1.0 - initial release
// ============================================================================
module delay_line_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic                  read_finish,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] wptr_s_q;
    logic [ADDR_WIDTH-1:0] offset_s_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  read_finish_q;
    logic                  accept;
    logic                  force_zero;

    assign accept = (state_q == ST_IDLE) && rd;

    // ------------------------------------------------------------------------
    // Optional fill tracking: the "too deep" decision is taken when the
    // request is accepted, from the fill level before any same-edge write.
    // ------------------------------------------------------------------------
`ifdef DELAY_LINE_FILL_TRACK_EN
    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0] fill_q;
    logic                empty_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q    <= '0;
            empty_s_q <= 1'b0;
        end else begin
            if (wr && (fill_q != FILL_MAX)) begin
                fill_q <= fill_q + (ADDR_WIDTH+1)'(1);
            end
            if (accept) begin
                empty_s_q <= ({1'b0, offset} >= fill_q);
            end
        end
    end

    assign force_zero = empty_s_q;
`else
    assign force_zero = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rd) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_MEM;
            ST_MEM:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wptr_q        <= '0;
            wptr_s_q      <= '0;
            offset_s_q    <= '0;
            raddr_q       <= '0;
            read_finish_q <= 1'b0;
            data_out_q    <= '0;
        end else begin
            state_q <= state_d;
            if (wr) begin
                wptr_q <= wptr_q + ADDR_WIDTH'(1);
            end
            // Snapshot pointer and offset before any write on this edge lands.
            if (accept) begin
                wptr_s_q   <= wptr_q;
                offset_s_q <= offset;
            end
            if (state_q == ST_ADDR) begin
                raddr_q <= wptr_s_q - ADDR_WIDTH'(1) - offset_s_q;
            end
            read_finish_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                data_out_q <= force_zero ? '0 : rdata_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sample storage (not reset). A write to the address being read in the
    // MEM cycle is forwarded so the read sees the new sample.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q] <= data_in;
        end
        if (state_q == ST_MEM) begin
            rdata_q <= (wr && (wptr_q == raddr_q)) ? data_in : mem_q[raddr_q];
        end
    end

    assign read_finish = read_finish_q;
    assign data_out    = data_out_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_delay_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_line_ram
// Purpose  : Self-checking bench for delay_line_ram. A history-array model
//            predicts busy, read_finish and data_out every cycle; directed
//            scenarios add explicit expected constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_line_ram;

    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic [DW-1:0] data_in;
    logic          rd;
    logic [AW-1:0] offset;
    logic          read_finish;
    logic [DW-1:0] data_out;
    logic          busy;

    always #5 clk = ~clk;

    delay_line_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .data_in     (data_in),
        .rd          (rd),
        .offset      (offset),
        .read_finish (read_finish),
        .data_out    (data_out),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the memory is indexed by (samples written mod DEPTH);
    // a request sees the value at that location as it stands after the
    // writes of the second edge following acceptance, and reports it one
    // edge later.
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_valid [DEPTH];
    int            m_wcount = 0;
    bit            m_active = 0;
    int            m_age    = 0;
    int            m_addr   = 0;
    int            m_off    = 0;
    int            m_fill   = 0;
    logic [DW-1:0] m_val    = '0;
    bit            m_val_known = 1;
    logic [DW-1:0] m_dout   = '0;
    bit            m_dout_known = 1;
    bit            m_finish = 0;

    task automatic model_reset();
        m_wcount     = 0;
        m_active     = 0;
        m_dout       = '0;
        m_dout_known = 1;
        m_finish     = 0;
    endtask

    task automatic model_edge();
        m_finish = 0;
        if (m_active) begin
            m_age++;
        end else if (rd) begin
            m_active = 1;
            m_age    = 0;
            m_off    = int'(offset);
            m_fill   = (m_wcount < DEPTH) ? m_wcount : DEPTH;
            m_addr   = (((m_wcount - 1 - m_off) % DEPTH) + DEPTH) % DEPTH;
        end
        if (wr) begin
            m_mem[m_wcount % DEPTH]   = data_in;
            m_valid[m_wcount % DEPTH] = 1;
            m_wcount++;
        end
        if (m_active && m_age == 2) begin
            m_val       = m_mem[m_addr];
            m_val_known = m_valid[m_addr];
`ifdef DELAY_LINE_FILL_TRACK_EN
            if (m_off >= m_fill) begin
                m_val       = '0;
                m_val_known = 1;
            end
`endif
        end
        if (m_active && m_age == 3) begin
            m_finish     = 1;
            m_dout       = m_val;
            m_dout_known = m_val_known;
            m_active     = 0;
        end
    endtask

    // One clock: drive at the falling edge, update model at the rising edge,
    // compare 1 time unit later, return at the next falling edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic [AW-1:0] o);
        wr      = w;
        data_in = d;
        rd      = r;
        offset  = o;
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("read_finish", {31'd0, read_finish}, {31'd0, m_finish});
        if (m_dout_known) check("data_out", {16'd0, data_out}, {16'd0, m_dout});
        @(negedge clk);
    endtask

    task automatic read_op(input logic w, input logic [DW-1:0] d, input logic [AW-1:0] o,
                           output logic [DW-1:0] val, output int lat);
        step(w, d, 1'b1, o);
        lat = 0;
        val = '0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, '0, 1'b0, '0);
            if (read_finish) begin
                lat = i;
                val = data_out;
                break;
            end
        end
        if (lat == 0) check("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        wr  = 1'b0;
        rd  = 1'b0;
        #1;
        model_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_read_finish", {31'd0, read_finish}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        int            lat;
        int            pulses;
        int            first_p;
        int            last_p;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0; offset = '0;
        @(negedge clk);
        @(negedge clk);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_read_finish", {31'd0, read_finish}, 32'd0);
        check("init_data_out", {16'd0, data_out}, 32'd0);
        rst = 1'b0;

        // Basic write 1,2,3 then reads at offsets 0 and 2.
        step(1'b1, 16'd1, 1'b0, '0);
        step(1'b1, 16'd2, 1'b0, '0);
        step(1'b1, 16'd3, 1'b0, '0);
        read_op(1'b0, '0, 13'd0, v, lat);
        check("basic_latency", lat, 32'd3);
        check("basic_off0", {16'd0, v}, 32'd3);
        read_op(1'b0, '0, 13'd2, v, lat);
        check("basic_off2", {16'd0, v}, 32'd1);

        // Read issued together with a write sees the previous sample.
        read_op(1'b1, 16'h7FFF, 13'd0, v, lat);
        check("same_edge_wr", {16'd0, v}, 32'd3);
        read_op(1'b0, '0, 13'd0, v, lat);
        check("following_rd", {16'd0, v}, 32'h7FFF);

        // Hold rd high for 12 cycles.
        pulses = 0; first_p = -1; last_p = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 13'($urandom_range(0, 3)));
            if (read_finish) begin
                pulses++;
                if (first_p < 0) first_p = i;
                last_p = i;
            end
        end
        check("hold_pulses", pulses, 32'd3);
        check("hold_spacing", last_p - first_p, 32'd8);
        step(1'b0, '0, 1'b0, '0);

        // Reset while the read is in MEM: aborted, no pulse afterwards.
        step(1'b0, '0, 1'b1, 13'd0);
        step(1'b0, '0, 1'b0, 13'd0);
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0);
        step(1'b1, 16'hAAAA, 1'b0, '0);
        step(1'b1, 16'h5555, 1'b0, '0);
        read_op(1'b0, '0, 13'd1, v, lat);
        check("after_rst_off1", {16'd0, v}, 32'hAAAA);
`ifdef DELAY_LINE_FILL_TRACK_EN
        read_op(1'b0, '0, 13'd5, v, lat);
        check("fill_too_deep", {16'd0, v}, 32'd0);
`endif

        // Wrap: 8200 samples, value = index.
        apply_reset();
        for (int i = 0; i < 8200; i++) step(1'b1, 16'(i), 1'b0, '0);
        read_op(1'b0, '0, 13'd0, v, lat);
        check("wrap_off0", {16'd0, v}, 32'd8199);
        read_op(1'b0, '0, 13'd8191, v, lat);
        check("wrap_off8191", {16'd0, v}, 32'd8);

        // Collision: oldest location overwritten in the MEM cycle.
        step(1'b0, '0, 1'b1, 13'd8191);
        step(1'b0, '0, 1'b0, '0);
        step(1'b1, 16'h1234, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        check("collision_finish", {31'd0, read_finish}, 32'd1);
        check("collision_data", {16'd0, data_out}, 32'h1234);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] o;
            o = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15)) : 13'($urandom);
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 3), o);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
